// File: rtl/cpsr_flags_pkg.sv
// Shared definitions for the CPSR flag block: FSM state encoding and NZCV bit positions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpsr_flags_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

endpackage

// File: rtl/cpsr_flag_mux.sv
// Forms the pending flag value: arithmetic ops take all four ALU flags, logical ops take C from the shifter and keep V.
// Latency: combinational.
// Backpressure: none.
module cpsr_flag_mux
  import cpsr_flags_pkg::*;
(
  input  logic       logic_op,
  input  logic [3:0] alu_nzcv,
  input  logic       shift_carry,
  input  logic       cur_v,
  output logic [3:0] shadow_val
);

  assign shadow_val[N_BIT] = alu_nzcv[N_BIT];
  assign shadow_val[Z_BIT] = alu_nzcv[Z_BIT];
  assign shadow_val[C_BIT] = logic_op ? shift_carry : alu_nzcv[C_BIT];
  assign shadow_val[V_BIT] = logic_op ? cur_v : alu_nzcv[V_BIT];

endmodule

// File: rtl/cpsr_flags.sv
// Architectural NZCV flags with a one-deep pending update committed by Write_PSR; optional SPSR under CPSR_SPSR_EN.
// Latency: committed/written flags visible one edge after the commit cycle.
// Backpressure: none; a new capture while pending overwrites (or follows a same-cycle commit).
module cpsr_flags
  import cpsr_flags_pkg::*;
(
  input  logic       clk,
  input  logic       Rst,
  input  logic       alu_valid,
  input  logic       set_flags,
  input  logic       logic_op,
  input  logic [3:0] alu_nzcv,
  input  logic       shift_carry,
  input  logic       Write_PSR,
  input  logic       discard,
  input  logic       msr_we,
  input  logic [3:0] msr_data,
`ifdef CPSR_SPSR_EN
  input  logic       save_psr,
  input  logic       restore_psr,
  output logic [3:0] SPSR,
`endif
  output logic [3:0] NZCV,
  output logic       flags_busy,
  output logic [7:0] commit_cnt
);

  state_t     state, state_nxt;
  logic [3:0] shadow, shadow_val, nzcv_nxt;
  logic       capture, commit, load_shadow;

  assign capture = alu_valid & set_flags;

  cpsr_flag_mux u_mux (
    .logic_op   (logic_op),
    .alu_nzcv   (alu_nzcv),
    .shift_carry(shift_carry),
    .cur_v      (NZCV[V_BIT]),
    .shadow_val (shadow_val)
  );

  always_ff @(posedge clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    commit      = 1'b0;
    load_shadow = 1'b0;
    nzcv_nxt    = NZCV;
    case (state)
      IDLE: begin
        if (capture) begin
          state_nxt   = PEND;
          load_shadow = 1'b1;
        end
      end
      PEND: begin
        // discard wins over a simultaneous Write_PSR
        if (discard) begin
          state_nxt = IDLE;
        end else begin
          commit = Write_PSR;
          if (capture) load_shadow = 1'b1;
          else if (Write_PSR) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (commit) nzcv_nxt = shadow;
    if (msr_we) begin
      nzcv_nxt    = msr_data;
      state_nxt   = IDLE;
      commit      = 1'b0;
      load_shadow = 1'b0;
    end
`ifdef CPSR_SPSR_EN
    if (restore_psr) begin
      nzcv_nxt    = SPSR;
      state_nxt   = IDLE;
      commit      = 1'b0;
      load_shadow = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      NZCV       <= 4'b0000;
      shadow     <= 4'b0000;
      commit_cnt <= 8'd0;
    end else begin
      NZCV <= nzcv_nxt;
      if (load_shadow) shadow <= shadow_val;
      if (commit) commit_cnt <= commit_cnt + 8'd1;
    end
  end

`ifdef CPSR_SPSR_EN
  // Save reads the pre-edge NZCV, so save+restore together swaps the two registers.
  always_ff @(posedge clk) begin
    if (Rst)           SPSR <= 4'b0000;
    else if (save_psr) SPSR <= NZCV;
  end
`endif

  assign flags_busy = (state == PEND);

endmodule

// File: tb/tb_cpsr_flags.sv
// Directed and randomized checks of cpsr_flags against a rule-level flag model.
module tb_cpsr_flags;

  logic       clk = 1'b0;
  logic       Rst, alu_valid, set_flags, logic_op, shift_carry;
  logic       Write_PSR, discard, msr_we;
  logic [3:0] alu_nzcv, msr_data;
  logic [3:0] NZCV;
  logic       flags_busy;
  logic [7:0] commit_cnt;
`ifdef CPSR_SPSR_EN
  logic       save_psr, restore_psr;
  logic [3:0] SPSR;
`endif

  int checks = 0;
  int errors = 0;

  // reference model: architectural flags, whether an update is pending, its value, commit count
  logic [3:0] m_nzcv, m_shadow, m_spsr;
  bit         m_pend;
  int         m_cnt;

  always #5 clk = ~clk;

  cpsr_flags dut (
    .clk        (clk),
    .Rst        (Rst),
    .alu_valid  (alu_valid),
    .set_flags  (set_flags),
    .logic_op   (logic_op),
    .alu_nzcv   (alu_nzcv),
    .shift_carry(shift_carry),
    .Write_PSR  (Write_PSR),
    .discard    (discard),
    .msr_we     (msr_we),
    .msr_data   (msr_data),
`ifdef CPSR_SPSR_EN
    .save_psr   (save_psr),
    .restore_psr(restore_psr),
    .SPSR       (SPSR),
`endif
    .NZCV       (NZCV),
    .flags_busy (flags_busy),
    .commit_cnt (commit_cnt)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    Rst = 0; alu_valid = 0; set_flags = 0; logic_op = 0; alu_nzcv = 0; shift_carry = 0;
    Write_PSR = 0; discard = 0; msr_we = 0; msr_data = 0;
`ifdef CPSR_SPSR_EN
    save_psr = 0; restore_psr = 0;
`endif
  endtask

  task automatic model_edge();
    logic [3:0] prev_nzcv, fresh;
    bit         cap, take_over;
    prev_nzcv = m_nzcv;
    if (Rst) begin
      m_nzcv = 0; m_shadow = 0; m_pend = 0; m_cnt = 0; m_spsr = 0;
      return;
    end
    cap   = alu_valid && set_flags;
    fresh = logic_op ? {alu_nzcv[3], alu_nzcv[2], shift_carry, m_nzcv[0]} : alu_nzcv;
    take_over = msr_we;
`ifdef CPSR_SPSR_EN
    take_over = take_over || restore_psr;
`endif
    if (take_over) begin
      m_pend = 0;
      m_nzcv = msr_data;
`ifdef CPSR_SPSR_EN
      if (restore_psr) m_nzcv = m_spsr;
`endif
    end else if (!m_pend) begin
      if (cap) begin m_shadow = fresh; m_pend = 1; end
    end else if (discard) begin
      m_pend = 0;
    end else begin
      if (Write_PSR) begin m_nzcv = m_shadow; m_cnt = (m_cnt + 1) % 256; end
      if (cap) m_shadow = fresh;
      else if (Write_PSR) m_pend = 0;
    end
`ifdef CPSR_SPSR_EN
    if (save_psr) m_spsr = prev_nzcv;
`endif
  endtask

  // one clock: advance model with the inputs present at the edge, then compare just after it
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, ".nzcv"}, {4'b0, NZCV}, {4'b0, m_nzcv});
    chk({tag, ".busy"}, {7'b0, flags_busy}, {7'b0, m_pend});
    chk({tag, ".cnt"}, commit_cnt, 8'(m_cnt));
`ifdef CPSR_SPSR_EN
    chk({tag, ".spsr"}, {4'b0, SPSR}, {4'b0, m_spsr});
`endif
  endtask

  initial begin
    m_nzcv = 0; m_shadow = 0; m_spsr = 0; m_pend = 0; m_cnt = 0;
    quiet();
    Rst = 1;
    step("reset0");
    step("reset1");
    chk("reset.nzcv_const", {4'b0, NZCV}, 8'h00);
    chk("reset.busy_const", {7'b0, flags_busy}, 8'h00);
    quiet();

    // 256 capture/commit pairs wrap the counter back to zero
    for (int i = 0; i < 256; i++) begin
      alu_valid = 1; set_flags = 1; alu_nzcv = 4'(i);
      step("wrap.cap");
      quiet(); Write_PSR = 1;
      step("wrap.commit");
      quiet();
    end
    chk("wrap.cnt_zero", commit_cnt, 8'h00);

    // basic capture and commit
    Rst = 1; step("r040"); quiet();
    alu_valid = 1; set_flags = 1; alu_nzcv = 4'b0110;
    step("c040.cap");
    chk("c040.busy_hi", {7'b0, flags_busy}, 8'h01);
    quiet(); Write_PSR = 1;
    step("c040.commit");
    quiet();
    chk("c040.nzcv", {4'b0, NZCV}, 8'h06);
    chk("c040.cnt", commit_cnt, 8'h01);
    chk("c040.busy_lo", {7'b0, flags_busy}, 8'h00);

    // logical op keeps V, takes C from shifter
    msr_we = 1; msr_data = 4'b0001; step("c041.msr"); quiet();
    alu_valid = 1; set_flags = 1; logic_op = 1; alu_nzcv = 4'b1000; shift_carry = 1;
    step("c041.cap");
    quiet(); Write_PSR = 1; step("c041.commit"); quiet();
    chk("c041.nzcv", {4'b0, NZCV}, 8'h0B);

    // discard drops the pending value; discard beats Write_PSR
    alu_valid = 1; set_flags = 1; alu_nzcv = 4'b1111; step("c042.cap");
    quiet(); discard = 1; Write_PSR = 1; step("c042.discard"); quiet();
    chk("c042.nzcv", {4'b0, NZCV}, 8'h0B);
    chk("c042.busy", {7'b0, flags_busy}, 8'h00);
    chk("c042.cnt", commit_cnt, 8'h02);

    // Write_PSR in IDLE is ignored
    Write_PSR = 1; step("idle_wr"); quiet();

    // MSR beats a same-cycle commit
    alu_valid = 1; set_flags = 1; alu_nzcv = 4'b0100; step("c043.cap");
    quiet(); msr_we = 1; msr_data = 4'b1001; Write_PSR = 1; step("c043.msr"); quiet();
    chk("c043.nzcv", {4'b0, NZCV}, 8'h09);
    chk("c043.cnt", commit_cnt, 8'h02);

    // back-to-back: capture with commit keeps the new value pending
    alu_valid = 1; set_flags = 1; alu_nzcv = 4'b0011; step("b2b.cap1");
    alu_nzcv = 4'b1100; Write_PSR = 1; step("b2b.cap2");
    quiet(); Write_PSR = 1; step("b2b.commit"); quiet();
    chk("b2b.nzcv", {4'b0, NZCV}, 8'h0C);

    // reset while pending
    alu_valid = 1; set_flags = 1; alu_nzcv = 4'b1010; step("c045.cap");
    quiet(); Rst = 1; Write_PSR = 1; step("c045.rst"); quiet();
    chk("c045.nzcv", {4'b0, NZCV}, 8'h00);
    chk("c045.busy", {7'b0, flags_busy}, 8'h00);

`ifdef CPSR_SPSR_EN
    msr_we = 1; msr_data = 4'b1010; step("c046.msr1"); quiet();
    save_psr = 1; step("c046.save"); quiet();
    msr_we = 1; msr_data = 4'b0000; step("c046.msr0"); quiet();
    restore_psr = 1; msr_we = 1; msr_data = 4'b0111; step("c046.restore"); quiet();
    chk("c046.nzcv", {4'b0, NZCV}, 8'h0A);
    msr_we = 1; msr_data = 4'b0101; step("swap.msr"); quiet();
    save_psr = 1; restore_psr = 1; step("swap"); quiet();
    chk("swap.nzcv", {4'b0, NZCV}, 8'h0A);
    chk("swap.spsr", {4'b0, SPSR}, 8'h05);
`endif

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      Rst         = ($urandom_range(0, 63) == 0);
      alu_valid   = 1'($urandom_range(0, 1));
      set_flags   = ($urandom_range(0, 3) != 0);
      logic_op    = 1'($urandom_range(0, 1));
      alu_nzcv    = 4'($urandom_range(0, 15));
      shift_carry = 1'($urandom_range(0, 1));
      Write_PSR   = 1'($urandom_range(0, 1));
      discard     = ($urandom_range(0, 7) == 0);
      msr_we      = ($urandom_range(0, 15) == 0);
      msr_data    = 4'($urandom_range(0, 15));
`ifdef CPSR_SPSR_EN
      save_psr    = ($urandom_range(0, 15) == 0);
      restore_psr = ($urandom_range(0, 15) == 0);
`endif
      step("rand");
    end
    quiet();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
